// File: rtl/ibex_multdiv_iter.sv
// Iterative MUL/DIV/REM retiring STEP bits per COMP cycle; optional MULTDIV_ITER_EARLY_EXIT_EN.
// Latency: out_valid_o is high after WIDTH/STEP+3 clock edges, counting the accept edge (fixed unless early exit).
// Backpressure: one op in flight; in_ready_o low until the result is consumed; result held while out_ready_i low.
module ibex_multdiv_iter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT = WIDTH / STEP;
    localparam int CW  = $clog2(CNT);

    localparam logic [1:0] OP_MULL = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_REM  = 2'd3;

    typedef enum logic [2:0] {IDLE, PREP, COMP, FIX, DONE} state_e;

    state_e             state;
    logic [1:0]         op_q;
    logic               sa_q, sb_q, bz_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   mplier, quo, divisor;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH:0]     rem;
    logic [CW-1:0]      count;

    logic               is_mul;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] acc_nx, mc_nx, prod_fix;
    logic [WIDTH-1:0]   mp_nx, quo_nx, res_fix;
    logic [WIDTH:0]     rem_nx;
    logic               comp_last;

    assign is_mul = ~op_q[1];
    // Two's complement negation maps MIN onto 2^(W-1), which is exactly |MIN| unsigned.
    assign a_abs  = sa_q ? -a_q : a_q;
    assign b_abs  = sb_q ? -b_q : b_q;

    // STEP chained stages: the multiplier shifts the multiplicand left so that leaving
    // COMP early still leaves the product correctly aligned.
    always_comb begin
        acc_nx = acc;
        mc_nx  = mcand;
        mp_nx  = mplier;
        rem_nx = rem;
        quo_nx = quo;
        for (int i = 0; i < STEP; i++) begin
            if (mp_nx[0]) acc_nx = acc_nx + mc_nx;
            mc_nx  = mc_nx << 1;
            mp_nx  = mp_nx >> 1;
            rem_nx = {rem_nx[WIDTH-1:0], quo_nx[WIDTH-1]};
            quo_nx = {quo_nx[WIDTH-2:0], 1'b0};
            if (rem_nx >= {1'b0, divisor}) begin
                rem_nx    = rem_nx - {1'b0, divisor};
                quo_nx[0] = 1'b1;
            end
        end
    end

`ifdef MULTDIV_ITER_EARLY_EXIT_EN
    assign comp_last = (count == '0) || (is_mul && (mp_nx == '0));
`else
    assign comp_last = (count == '0);
`endif

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -acc : acc;
        res_fix  = '0;
        case (op_q)
            OP_MULL: res_fix = prod_fix[WIDTH-1:0];
            OP_MULH: res_fix = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV:  res_fix = ((sa_q ^ sb_q) & ~bz_q) ? -quo : quo;
            OP_REM:  res_fix = sa_q ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            default: res_fix = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            count       <= '0;
            op_q        <= OP_MULL;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            bz_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            mplier      <= '0;
            quo         <= '0;
            divisor     <= '0;
            acc         <= '0;
            mcand       <= '0;
            rem         <= '0;
        end else if (state != IDLE && kill_i) begin
            state       <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            result_o    <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A request accepted together with a kill is dropped.
                    if (in_valid_i && !kill_i) begin
                        op_q       <= op_i;
                        a_q        <= op_a_i;
                        b_q        <= op_b_i;
                        sa_q       <= op_a_i[WIDTH-1] & signed_mode_i[0];
                        sb_q       <= op_b_i[WIDTH-1] & signed_mode_i[1];
                        bz_q       <= (op_b_i == '0);
                        in_ready_o <= 1'b0;
                        state      <= PREP;
                    end
                end
                PREP: begin
                    acc     <= '0;
                    mcand   <= {{WIDTH{1'b0}}, a_abs};
                    mplier  <= b_abs;
                    rem     <= '0;
                    quo     <= a_abs;
                    divisor <= b_abs;
                    count   <= CW'(CNT - 1);
                    state   <= COMP;
`ifdef MULTDIV_ITER_EARLY_EXIT_EN
                    if (!is_mul && bz_q) begin
                        result_o    <= (op_q == OP_DIV) ? {WIDTH{1'b1}} : a_q;
                        out_valid_o <= 1'b1;
                        count       <= '0;
                        state       <= DONE;
                    end
`endif
                end
                COMP: begin
                    if (is_mul) begin
                        acc    <= acc_nx;
                        mcand  <= mc_nx;
                        mplier <= mp_nx;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                    end
                    if (comp_last) begin
                        count <= '0;
                        state <= FIX;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                FIX: begin
                    result_o    <= res_fix;
                    out_valid_o <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        result_o    <= '0;
                        in_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed bench for ibex_multdiv_iter: STEP=1 and STEP=4 instances, scoreboard of expected results.
module tb_ibex_multdiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op_s = 2'd0, sm_s = 2'd0;
    logic [31:0] a_s = '0, b_s = '0;
    logic        in_valid1 = 1'b0, in_valid4 = 1'b0;
    logic        out_ready1 = 1'b1, out_ready4 = 1'b1;
    logic        kill1 = 1'b0, kill4 = 1'b0;
    logic        in_ready1, in_ready4, out_valid1, out_valid4;
    logic [31:0] result1, result4;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ibex_multdiv_iter #(.WIDTH(32), .STEP(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .op_i(op_s), .signed_mode_i(sm_s), .op_a_i(a_s), .op_b_i(b_s), .kill_i(kill1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1), .result_o(result1));

    ibex_multdiv_iter #(.WIDTH(32), .STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
        .op_i(op_s), .signed_mode_i(sm_s), .op_a_i(a_s), .op_b_i(b_s), .kill_i(kill4),
        .out_valid_o(out_valid4), .out_ready_i(out_ready4), .result_o(result4));

    function automatic logic ov(input bit sel);
        return sel ? out_valid4 : out_valid1;
    endfunction
    function automatic logic ir(input bit sel);
        return sel ? in_ready4 : in_ready1;
    endfunction
    function automatic logic [31:0] res(input bit sel);
        return sel ? result4 : result1;
    endfunction

    // Reference: extend per signed_mode to 64 bits; truncating division, div-by-zero rules.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
        longint al, bl;
        logic [63:0] p;
        al = sm[0] ? {{32{a[31]}}, a} : {32'h0, a};
        bl = sm[1] ? {{32{b[31]}}, b} : {32'h0, b};
        case (op)
            2'd0: begin p = al * bl; return p[31:0]; end
            2'd1: begin p = al * bl; return p[63:32]; end
            2'd2: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = al / bl;
                return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = al % bl;
                return p[31:0];
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Latency counts clock edges with the accept edge as edge 1.
    task automatic run_op(input string tag, input bit sel, input logic [1:0] op,
                          input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        int edges;
        int lat;
        logic [31:0] held;
        lat = sel ? 11 : 35;
        exp_q.push_back(model(op, sm, a, b));
        @(negedge clk);
        op_s = op; sm_s = sm; a_s = a; b_s = b;
        if (sel) begin in_valid4 = 1'b1; out_ready4 = (hold == 0); end
        else     begin in_valid1 = 1'b1; out_ready1 = (hold == 0); end
        @(posedge clk); #1;
        in_valid1 = 1'b0; in_valid4 = 1'b0;
        edges = 1;
        while (!ov(sel) && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, ".valid"}, 64'(ov(sel)), 64'(1));
        chk({tag, ".latency"}, 64'(edges), 64'(lat));
        if (hold > 0) begin
            held = res(sel);
            repeat (hold) begin
                @(posedge clk); #1;
                chk({tag, ".held"}, 64'(res(sel)), 64'(held));
                chk({tag, ".in_ready_done"}, 64'(ir(sel)), 64'(0));
            end
            out_ready1 = 1'b1; out_ready4 = 1'b1;
        end
        chk({tag, ".result"}, 64'(res(sel)), 64'(exp_q.pop_front()));
        @(posedge clk); #1;
        chk({tag, ".consumed"}, 64'(ov(sel)), 64'(0));
        chk({tag, ".ready_back"}, 64'(ir(sel)), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready1", 64'(in_ready1), 64'(1));
        chk("reset.out_valid1", 64'(out_valid1), 64'(0));
        chk("reset.result1", 64'(result1), 64'(0));
        chk("reset.in_ready4", 64'(in_ready4), 64'(1));
        chk("reset.out_valid4", 64'(out_valid4), 64'(0));
        rst = 1'b0;

        run_op("mull_s1", 1'b0, 2'd0, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 0);
        run_op("mulh_min_s4", 1'b1, 2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mulhu_s4", 1'b1, 2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_m7_2", 1'b0, 2'd2, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_op("rem_m7_2", 1'b1, 2'd3, 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        run_op("div_ovf", 1'b0, 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 1'b1, 2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_by0", 1'b0, 2'd2, 2'b11, 32'h0000_1234, 32'h0000_0000, 0);
        run_op("rem_by0", 1'b0, 2'd3, 2'b11, 32'h0000_1234, 32'h0000_0000, 0);
        run_op("div_by0_s4", 1'b1, 2'd2, 2'b11, 32'hFFFF_FF00, 32'h0000_0000, 0);
        run_op("rem_by0_s4", 1'b1, 2'd3, 2'b11, 32'hFFFF_FF00, 32'h0000_0000, 0);
        run_op("divu_big", 1'b0, 2'd2, 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 0);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            run_op($sformatf("rand%0d", i), 1'(i % 2), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), ra, rb, 0);
        end

        // Kill during COMP cycle 5: no result, ready again next cycle.
        @(negedge clk);
        op_s = 2'd0; sm_s = 2'b00; a_s = 32'd1234; b_s = 32'd5678; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (5) @(posedge clk);
        #1 kill1 = 1'b1;
        @(posedge clk); #1;
        kill1 = 1'b0;
        chk("kill.in_ready", 64'(in_ready1), 64'(1));
        chk("kill.out_valid", 64'(out_valid1), 64'(0));
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid1) seen = 1'b1; end
        chk("kill.never_valid", 64'(seen), 64'(0));
        run_op("after_kill", 1'b0, 2'd3, 2'b11, 32'hFFFF_FF9C, 32'h0000_0007, 0);

        // Kill together with an accept in IDLE drops the request.
        @(negedge clk);
        in_valid4 = 1'b1; kill4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0; kill4 = 1'b0;
        chk("kill_idle.in_ready", 64'(in_ready4), 64'(1));
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (out_valid4) seen = 1'b1; end
        chk("kill_idle.never_valid", 64'(seen), 64'(0));

        run_op("hold_done", 1'b0, 2'd0, 2'b01, 32'hFFFF_FFF0, 32'h0001_0001, 10);
        run_op("hold_done_s4", 1'b1, 2'd2, 2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFF3, 10);

        // Reset in the middle of COMP.
        @(negedge clk);
        op_s = 2'd2; sm_s = 2'b00; a_s = 32'd1000; b_s = 32'd7; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid.in_ready", 64'(in_ready1), 64'(1));
        chk("rst_mid.out_valid", 64'(out_valid1), 64'(0));
        chk("rst_mid.result", 64'(result1), 64'(0));
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid1) seen = 1'b1; end
        chk("rst_mid.never_valid", 64'(seen), 64'(0));
        run_op("after_rst", 1'b0, 2'd1, 2'b10, 32'h1234_5678, 32'h8765_4321, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
